// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one 4-phase request/valid cache port among NREQ requesters.
// Optional watchdog on the cache response is enabled with `define ARB_TIMEOUT_EN.
module cache_port_arbiter #(
  parameter int NREQ         = 2,
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int OPWIDTH      = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_request,
  input  logic [NREQ*OPWIDTH-1:0]      req_op,
  input  logic [NREQ*ADDRESSWIDTH-1:0] req_addr,
  input  logic [NREQ*DATAWIDTH-1:0]    req_wdata,
  output logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_evict,
  output logic [DATAWIDTH-1:0]         req_rdata,
  output logic [OPWIDTH-1:0]           cache_op,
  output logic [ADDRESSWIDTH-1:0]      cache_addr,
  output logic [DATAWIDTH-1:0]         cache_wdata,
  input  logic [DATAWIDTH-1:0]         cache_rdata,
  output logic                         cache_request,
  input  logic                         cache_valid,
  input  logic                         cache_evict,
`ifdef ARB_TIMEOUT_EN
  output logic                         timeout_err,
`endif
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         busy
);

  localparam int GW = $clog2(NREQ);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_REQ        = 3'd1;
  localparam logic [2:0] S_WAIT_VALID = 3'd2;
  localparam logic [2:0] S_RELEASE    = 3'd3;
  localparam logic [2:0] S_DROP       = 3'd4;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("cache_port_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
  end

  logic [2:0]           state;
  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;
  logic                 found;
  logic [DATAWIDTH-1:0] rdata_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;
`endif

  // Scan requesters starting at rr_ptr so the last winner is visited last.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = GW'((32'(rr_ptr) + i) % NREQ);
      if (!found && req_request[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign req_rdata = rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      cache_op      <= '0;
      cache_addr    <= '0;
      cache_wdata   <= '0;
      cache_request <= 1'b0;
      req_valid     <= '0;
      req_evict     <= '0;
      rdata_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      tcnt          <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id    <= pick;
            cache_op    <= req_op[32'(pick)*OPWIDTH +: OPWIDTH];
            cache_addr  <= req_addr[32'(pick)*ADDRESSWIDTH +: ADDRESSWIDTH];
            cache_wdata <= req_wdata[32'(pick)*DATAWIDTH +: DATAWIDTH];
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          cache_request <= 1'b1;
          state         <= S_WAIT_VALID;
`ifdef ARB_TIMEOUT_EN
          tcnt          <= '0;
`endif
        end
        S_WAIT_VALID: begin
          if (cache_valid) begin
            rdata_q             <= cache_rdata;
            req_valid[grant_id] <= 1'b1;
            req_evict[grant_id] <= cache_evict;
            state               <= S_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          // Abandon the cache transaction and complete the requester with zero data.
          else if (tcnt == CW'(TIMEOUT - 1)) begin
            cache_request       <= 1'b0;
            timeout_err         <= 1'b1;
            rdata_q             <= '0;
            req_valid[grant_id] <= 1'b1;
            req_evict[grant_id] <= 1'b0;
            state               <= S_RELEASE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          if (!req_request[grant_id]) begin
            cache_request <= 1'b0;
            state         <= S_DROP;
          end
        end
        S_DROP: begin
          if (!cache_valid) begin
            req_valid <= '0;
            req_evict <= '0;
            rr_ptr    <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
